// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: time-shares one registered S-box between SubBytes (128b state) and SubWord (32b word).
// Define SBOX_SHARE_RR_EN for round-robin arbitration; default is fixed priority ks over st.
module sbox_share_ctrl #(
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    input  logic [127:0] st_data,
    output logic         st_ready,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         ks_valid,
    input  logic [31:0]  ks_data,
    output logic         ks_ready,
    output logic         ks_done,
    output logic [31:0]  ks_result,
    output logic [7:0]   sbox_a,
    input  logic [7:0]   sbox_c,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam logic [3:0] DRAIN_LAST = 4'(SBOX_LAT - 1);
    state_t                   state;
    logic                     owner_ks;
    logic                     grant_ks;
    logic [3:0]               cnt;
    logic [3:0]               last_idx;
    logic [127:0]             opnd;
    logic [127:0]             acc;
    logic [SBOX_LAT-1:0]      tag_v;
    logic [SBOX_LAT-1:0][3:0] tag_i;
`ifdef SBOX_SHARE_RR_EN
    logic last_ks;
    assign grant_ks = ks_valid && !(st_valid && last_ks);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last_ks <= 1'b0;
        else if (state == IDLE && (st_valid || ks_valid))
            last_ks <= grant_ks;
`else
    assign grant_ks = ks_valid;
`endif
    assign last_idx = owner_ks ? 4'd3 : 4'd15;
    assign sbox_a   = (state == ISSUE) ? opnd[{cnt, 3'b000} +: 8] : 8'h00;
    assign busy     = (state != IDLE);
    // Each issued byte carries its index down a tag line matching the S-box latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_ks  <= 1'b0;
            cnt       <= 4'd0;
            opnd      <= '0;
            acc       <= '0;
            tag_v     <= '0;
            tag_i     <= '0;
            st_ready  <= 1'b0;
            ks_ready  <= 1'b0;
            st_done   <= 1'b0;
            ks_done   <= 1'b0;
            st_result <= '0;
            ks_result <= '0;
        end else begin
            st_ready <= 1'b0;
            ks_ready <= 1'b0;
            st_done  <= 1'b0;
            ks_done  <= 1'b0;
            for (int i = SBOX_LAT - 1; i > 0; i--) begin
                tag_v[i] <= tag_v[i-1];
                tag_i[i] <= tag_i[i-1];
            end
            tag_v[0] <= (state == ISSUE);
            tag_i[0] <= cnt;
            if (tag_v[SBOX_LAT-1])
                acc[{tag_i[SBOX_LAT-1], 3'b000} +: 8] <= sbox_c;
            case (state)
                IDLE: if (st_valid || ks_valid) begin
                    owner_ks <= grant_ks;
                    ks_ready <= grant_ks;
                    st_ready <= !grant_ks;
                    opnd     <= grant_ks ? {96'h0, ks_data} : st_data;
                    cnt      <= 4'd0;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= (cnt == last_idx) ? 4'd0 : cnt + 4'd1;
                    state <= (cnt == last_idx) ? DRAIN : ISSUE;
                end
                DRAIN: begin
                    cnt   <= cnt + 4'd1;
                    state <= (cnt == DRAIN_LAST) ? DONE : DRAIN;
                end
                DONE: begin
                    state   <= IDLE;
                    ks_done <= owner_ks;
                    st_done <= !owner_ks;
                    if (owner_ks)
                        ks_result <= acc[31:0];
                    else
                        st_result <= acc;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// tb_sbox_share_ctrl: randomized scoreboard bench; the reference predicts grants, timing and
// results from the arbitration rules and a GF(2^8)-derived S-box table.
`timescale 1ns/1ps
module tb_sbox_share_ctrl;
    localparam int LAT = 1;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         st_valid = 1'b0;
    logic         ks_valid = 1'b0;
    logic [127:0] st_data = '0;
    logic [31:0]  ks_data = '0;
    logic         st_ready, st_done, ks_ready, ks_done, busy;
    logic [127:0] st_result;
    logic [31:0]  ks_result;
    logic [7:0]   sbox_a, sbox_c;
    logic [7:0]   sb [256];
    logic [7:0]   pipe [LAT];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        bit           ks;
        logic [127:0] res;
        int           due;
    } exp_t;
    exp_t         q[$];
    exp_t         e;
    int           free_at = 0;
    int           acc_cyc = 0;
    int           rdy_cyc = -1;
    bit           rdy_ks = 1'b0;
    bit           gk;
    int           n;
    logic [127:0] res;
    logic [1:0]   rexp;
`ifdef SBOX_SHARE_RR_EN
    bit           last_ks_m = 1'b0;
`endif

    sbox_share_ctrl #(.SBOX_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready), .st_done(st_done), .st_result(st_result),
        .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready), .ks_done(ks_done), .ks_result(ks_result),
        .sbox_a(sbox_a), .sbox_c(sbox_c), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural registered S-box with LAT cycles of latency.
    always @(posedge clk) begin
        pipe[0] <= sb[sbox_a];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sbox_c = pipe[LAT-1];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: checks handshakes and busy every cycle, pops the scoreboard on done, predicts grants.
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if ({st_ready, ks_ready, st_done, ks_done, busy} != 5'b0 || sbox_a != 8'h00 || st_result != '0 || ks_result != '0) begin
                errors++;
                $display("FAIL reset_state: rdy=%b%b done=%b%b busy=%b a=%h st=%h ks=%h, required all zero",
                         st_ready, ks_ready, st_done, ks_done, busy, sbox_a, st_result, ks_result);
            end
            q.delete();
            free_at = 0;
            acc_cyc = 0;
            rdy_cyc = -1;
`ifdef SBOX_SHARE_RR_EN
            last_ks_m = 1'b0;
`endif
        end else begin
            rexp = (rdy_cyc == cyc) ? (rdy_ks ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if ({st_ready, ks_ready} != rexp) begin
                errors++;
                $display("FAIL ready cyc %0d: st/ks ready=%b, required %b", cyc, {st_ready, ks_ready}, rexp);
            end
            checks++;
            if (busy != (cyc >= acc_cyc && cyc < free_at)) begin
                errors++;
                $display("FAIL busy cyc %0d: got %b, required %b", cyc, busy, !busy);
            end
            if (st_done || ks_done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done cyc %0d: st_done=%b ks_done=%b, required none", cyc, st_done, ks_done);
                end else begin
                    e = q.pop_front();
                    checks += 3;
                    if ({st_done, ks_done} != {!e.ks, e.ks}) begin
                        errors++;
                        $display("FAIL done_owner cyc %0d: st/ks done=%b, required %b", cyc, {st_done, ks_done}, {!e.ks, e.ks});
                    end
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL done_latency: done at cyc %0d, required %0d", cyc, e.due);
                    end
                    if (e.ks ? (ks_result != e.res[31:0]) : (st_result != e.res)) begin
                        errors++;
                        $display("FAIL result ks=%0b: got st=%h ks=%h, required %h", e.ks, st_result, ks_result, e.res);
                    end
                end
            end else if (q.size() != 0 && cyc > q[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_done: no done by cyc %0d, required at %0d", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (cyc >= free_at && (st_valid || ks_valid)) begin
`ifdef SBOX_SHARE_RR_EN
                gk = ks_valid && !(st_valid && last_ks_m);
                last_ks_m = gk;
`else
                gk = ks_valid;
`endif
                n       = gk ? 4 : 16;
                rdy_cyc = cyc + 1;
                rdy_ks  = gk;
                acc_cyc = cyc + 1;
                free_at = cyc + 1 + n + 1 + LAT;
                res     = '0;
                for (int i = 0; i < n; i++) res[8*i +: 8] = sb[gk ? ks_data[8*i +: 8] : st_data[8*i +: 8]];
                q.push_back('{gk, res, free_at});
            end
        end
    end

    task automatic req_st(input logic [127:0] d, input bit keep);
        bit got = 1'b0;
        st_data  = d;
        st_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = st_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL st_ready_timeout: no st_ready in 200 cycles, required one");
        end
        @(posedge clk);
        #1;
        if (!keep) st_valid = 1'b0;
    endtask

    task automatic req_ks(input logic [31:0] d);
        bit got = 1'b0;
        ks_data  = d;
        ks_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = ks_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ks_ready_timeout: no ks_ready in 200 cycles, required one");
        end
        @(posedge clk);
        #1;
        ks_valid = 1'b0;
    endtask

    task automatic expect_result(input bit ks, input logic [127:0] want);
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = ks ? ks_done : st_done;
        end
        checks++;
        if (!got || (ks ? {96'h0, ks_result} : st_result) != want) begin
            errors++;
            $display("FAIL known_vector ks=%0b: done=%0b st=%h ks=%h, required %h", ks, got, st_result, ks_result, want);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (q.size() == 0);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: %0d transactions outstanding, required 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mode, d1, d2;
        logic [127:0] d;
        for (int i = 0; i < 256; i++) sb[i] = sbox_f(8'(i));
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        req_ks(32'h03020100);
        expect_result(1'b1, {96'h0, 32'h7b777c63});
        wait_idle();
        req_st(128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
        expect_result(1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63);
        wait_idle();
        fork
            req_ks($urandom);
            req_st(rand128(), 1'b0);
        join
        wait_idle();
        req_ks($urandom);
        wait_idle();
        fork
            req_ks($urandom);
            req_st(rand128(), 1'b0);
        join
        wait_idle();
        req_st(rand128(), 1'b0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({st_ready, ks_ready, st_done, ks_done, busy} != 5'b0 || sbox_a != 8'h00 || st_result != '0 || ks_result != '0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b%b done=%b%b busy=%b a=%h st=%h ks=%h, required all zero",
                     st_ready, ks_ready, st_done, ks_done, busy, sbox_a, st_result, ks_result);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        req_ks(32'h03020100);
        expect_result(1'b1, {96'h0, 32'h7b777c63});
        wait_idle();
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(r * 16 + j);
            req_st(d, r < 15);
        end
        wait_idle();
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 3);
            d1   = $urandom_range(0, 8);
            d2   = (mode == 2) ? d1 : $urandom_range(0, 8);
            fork
                if (mode != 1) begin
                    repeat (d1) @(posedge clk);
                    #1 req_st(rand128(), 1'b0);
                end
                if (mode != 0) begin
                    repeat (d2) @(posedge clk);
                    #1 req_ks($urandom);
                end
            join
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
